tick_scheduler: RTL and testbench

- Central time-base controller for the game.
- Replaces ripple-divided clocks with synchronous one-cycle enable pulses, all in the single `clk` domain.
- One shared prescaler produces a base tick; N programmable channels derive game-rate ticks from it (sprite animation, movement, blink, attack pacing).
- A one-shot countdown timer with start/busy/done handshake sequences timed phases such as attack windows. Pause freezes all of it.

---
 rtl/tick_scheduler.sv | 172 +++++++++++++++++
 tb/tb_tick_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// Purpose: central time base; one prescaler, N_CH divided tick channels, and a one-shot countdown timer. Build macro TICK_SCHED_SIM_FAST_EN forces a 10-cycle base tick.
// Latency: base_tick 1 cycle after the prescaler wraps; tick[i] 1 cycle after its base_tick; timer_done 1 cycle after the final base_tick.
// Backpressure: none; pause freezes every counter/pulse register, masks pulse outputs, and ignores config writes and timer starts.
module tick_scheduler #(
    parameter int CLK_HZ  = 100000000,
    parameter int BASE_HZ = 1000,
    parameter int N_CH    = 4,
    parameter int DIV_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pause,
    input  logic [N_CH-1:0]  ch_en,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             base_tick,
    output logic [N_CH-1:0]  tick,
    input  logic             timer_start,
    input  logic [DIV_W-1:0] timer_len,
    output logic             timer_busy,
    output logic             timer_done
);

`ifdef TICK_SCHED_SIM_FAST_EN
    localparam int PRE_MAX_I = 9;
`else
    localparam int PRE_MAX_I = CLK_HZ / BASE_HZ - 1;
`endif
    localparam int               PRE_W   = (PRE_MAX_I < 1) ? 1 : $clog2(PRE_MAX_I + 1);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_MAX_I);

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_RUN  = 2'd1,
        T_DONE = 2'd2
    } tstate_e;

    // Power-up divisors: 1 Hz, 10 Hz, 20 Hz, then every base tick.
    function automatic logic [DIV_W-1:0] div_rst(input int ch);
        case (ch)
            0:       return DIV_W'(1000);
            1:       return DIV_W'(100);
            2:       return DIV_W'(50);
            default: return DIV_W'(1);
        endcase
    endfunction

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             base_tick_q, base_tick_d;
    logic [DIV_W-1:0] cnt_q [N_CH];
    logic [DIV_W-1:0] cnt_d [N_CH];
    logic [DIV_W-1:0] div_q [N_CH];
    logic [DIV_W-1:0] div_d [N_CH];
    logic [DIV_W-1:0] div_m1 [N_CH];
    logic [N_CH-1:0]  tick_q, tick_d;
    logic [DIV_W-1:0] rem_q, rem_d;
    tstate_e          state_q, state_d;

    // Prescaler: free-running wrap counter; the pulse is registered off the wrap.
    always_comb begin
        pre_cnt_d   = pre_cnt_q;
        base_tick_d = base_tick_q;
        if (!pause) begin
            base_tick_d = (pre_cnt_q == PRE_MAX);
            pre_cnt_d   = (pre_cnt_q == PRE_MAX) ? '0 : pre_cnt_q + PRE_W'(1);
        end
    end

    // Terminal count per channel; a zero divisor behaves as one.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            div_m1[i] = (div_q[i] == '0) ? '0 : div_q[i] - DIV_W'(1);
        end
    end

    // Channels: a divisor write wins over a due tick; a disabled channel sits at zero.
    always_comb begin
        tick_d = tick_q;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            div_d[i] = div_q[i];
            if (!pause) begin
                tick_d[i] = 1'b0;
                if (cfg_we && (cfg_ch == 3'(i))) begin
                    div_d[i] = cfg_div;
                    cnt_d[i] = '0;
                end else if (!ch_en[i]) begin
                    cnt_d[i] = '0;
                end else if (base_tick_q) begin
                    if (cnt_q[i] == div_m1[i]) begin
                        cnt_d[i]  = '0;
                        tick_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + DIV_W'(1);
                    end
                end
            end
        end
    end

    // Timer next state: starts only from IDLE; a base tick in the start cycle is not counted.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (!pause) begin
            case (state_q)
                T_IDLE: begin
                    if (timer_start) begin
                        if (timer_len != '0) begin
                            rem_d   = timer_len;
                            state_d = T_RUN;
                        end else begin
                            state_d = T_DONE;
                        end
                    end
                end
                T_RUN: begin
                    if (base_tick_q) begin
                        rem_d = rem_q - DIV_W'(1);
                        if (rem_q == DIV_W'(1)) begin
                            state_d = T_DONE;
                        end
                    end
                end
                T_DONE:  state_d = T_IDLE;
                default: state_d = T_IDLE;
            endcase
        end
    end

    // Outputs: pulses are masked while paused but their registers hold, so none is lost on resume.
    always_comb begin
        base_tick  = base_tick_q & ~pause;
        tick       = tick_q & ch_en & {N_CH{~pause}};
        timer_busy = (state_q == T_RUN);
        timer_done = (state_q == T_DONE) & ~pause;
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt_q   <= '0;
            base_tick_q <= 1'b0;
            tick_q      <= '0;
            rem_q       <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= div_rst(i);
            end
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            base_tick_q <= base_tick_d;
            tick_q      <= tick_d;
            rem_q       <= rem_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                div_q[i] <= div_d[i];
            end
        end
    end

    // Timer state register; reset aborts a run without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= T_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler with a 10-cycle base tick (CLK_HZ/BASE_HZ = 10).
// A reference model counts active (unpaused) cycles, base ticks seen per channel and timer ticks left.
// Directed phases pin the model with literal timings, then a randomized phase runs against it.
module tb_tick_scheduler;
    localparam int N = 4;
    localparam int W = 16;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic         clk = 1'b0;
    logic         reset, pause, cfg_we, timer_start;
    logic [N-1:0] ch_en;
    logic [2:0]   cfg_ch;
    logic [W-1:0] cfg_div, timer_len;
    logic         base_tick, timer_busy, timer_done;
    logic [N-1:0] tick;

    always #5 clk = ~clk;

    tick_scheduler #(
        .CLK_HZ (1000),
        .BASE_HZ(100),
        .N_CH   (N),
        .DIV_W  (W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pause      (pause),
        .ch_en      (ch_en),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .base_tick  (base_tick),
        .tick       (tick),
        .timer_start(timer_start),
        .timer_len  (timer_len),
        .timer_busy (timer_busy),
        .timer_done (timer_done)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic clk_adv();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    bit m_valid = 1'b0;
    int m_act;
    bit m_bt;
    int m_seen [N];
    int m_div  [N];
    bit m_pend [N];
    int m_tmode;
    int m_left;

    function automatic int eff_div(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    // A paused cycle does not exist for the model: nothing advances.
    always @(posedge clk) begin
        bit old_bt;
        if (reset) begin
            m_valid = 1'b1;
            m_act   = 0;
            m_bt    = 1'b0;
            m_tmode = M_IDLE;
            m_left  = 0;
            for (int i = 0; i < N; i++) begin
                m_seen[i] = 0;
                m_pend[i] = 1'b0;
                m_div[i]  = (i == 0) ? 1000 : (i == 1) ? 100 : (i == 2) ? 50 : 1;
            end
        end else if (!pause) begin
            old_bt = m_bt;
            m_act++;
            m_bt = ((m_act % 10) == 0);
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 1'b0;
                if (cfg_we && (int'(cfg_ch) == i)) begin
                    m_div[i]  = int'(cfg_div);
                    m_seen[i] = 0;
                end else if (!ch_en[i]) begin
                    m_seen[i] = 0;
                end else if (old_bt) begin
                    m_seen[i]++;
                    if (m_seen[i] >= eff_div(m_div[i])) begin
                        m_seen[i] = 0;
                        m_pend[i] = 1'b1;
                    end
                end
            end
            case (m_tmode)
                M_IDLE: begin
                    if (timer_start) begin
                        if (timer_len != '0) begin
                            m_left  = int'(timer_len);
                            m_tmode = M_RUN;
                        end else begin
                            m_tmode = M_DONE;
                        end
                    end
                end
                M_RUN: begin
                    if (old_bt) begin
                        m_left--;
                        if (m_left == 0) m_tmode = M_DONE;
                    end
                end
                default: m_tmode = M_IDLE;
            endcase
        end
    end

    // Compare every cycle, mid-period.
    always @(negedge clk) begin
        logic [N-1:0] exp_tick;
        if (m_valid) begin
            for (int i = 0; i < N; i++) exp_tick[i] = m_pend[i] & ch_en[i] & ~pause;
            check("base_tick", 32'(base_tick), 32'(m_bt & ~pause));
            check("tick", 32'(tick), 32'(exp_tick));
            check("timer_busy", 32'(timer_busy), 32'(m_tmode == M_RUN));
            check("timer_done", 32'(timer_done), 32'((m_tmode == M_DONE) && !pause));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    int first, second, t2a, t2b, t2c, n3, bad, nbt, done_at, ndone, npulse, busy_gaps, pause_left;
    bit prev_bt, bt_ok, done_prev_bt, done_busy;

    initial begin
        reset = 1'b1; pause = 1'b0; ch_en = '0; cfg_we = 1'b0; cfg_ch = '0;
        cfg_div = '0; timer_start = 1'b0; timer_len = '0;
        repeat (5) clk_adv();
        @(negedge clk);
        check("rst_base_tick", 32'(base_tick), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_busy", 32'(timer_busy), 0);
        check("rst_done", 32'(timer_done), 0);
        clk_adv();
        reset = 1'b0;

        // first base tick in cycle 10 after release, then every 10
        first = -1; second = -1;
        for (int k = 0; k <= 25; k++) begin
            @(negedge clk);
            if (base_tick) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            if (k < 25) clk_adv();
        end
        check("first_base_tick_cycle", 32'(first), 10);
        check("second_base_tick_cycle", 32'(second), 20);

        // ch2 divisor 3 -> 30-cycle period, one cycle behind its base tick
        clk_adv();
        cfg_we = 1'b1; cfg_ch = 3'd2; cfg_div = 16'd3; ch_en = 4'b0100;
        clk_adv();
        cfg_we = 1'b0;
        t2a = -1; t2b = -1; t2c = -1; bt_ok = 1'b0; prev_bt = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tick[2]) begin
                if (t2a < 0) begin t2a = k; bt_ok = prev_bt; end
                else if (t2b < 0) t2b = k;
                else if (t2c < 0) t2c = k;
            end
            prev_bt = base_tick;
            clk_adv();
        end
        check("ch2_period_1", 32'(t2b - t2a), 30);
        check("ch2_period_2", 32'(t2c - t2b), 30);
        check("ch2_follows_base_tick", 32'(bt_ok), 1);

        // ch3 divisor 0 -> tick after every base tick
        cfg_we = 1'b1; cfg_ch = 3'd3; cfg_div = 16'd0; ch_en = 4'b1000;
        clk_adv();
        cfg_we = 1'b0;
        repeat (11) clk_adv();
        n3 = 0; bad = 0; prev_bt = 1'b0;
        for (int k = 0; k <= 50; k++) begin
            @(negedge clk);
            if (k > 0) begin
                if (tick[3]) n3++;
                if (tick[3] != prev_bt) bad++;
            end
            prev_bt = base_tick;
            clk_adv();
        end
        check("ch3_ticks_per_50", 32'(n3), 5);
        check("ch3_tracks_base_tick", 32'(bad), 0);

        // timer length 4, with an ignored restart mid-run
        ch_en = '0;
        timer_start = 1'b1; timer_len = 16'd4;
        clk_adv();
        timer_start = 1'b0;
        @(negedge clk);
        check("timer_busy_after_start", 32'(timer_busy), 1);
        nbt = base_tick ? 1 : 0;
        prev_bt = base_tick;
        done_at = -1; busy_gaps = 0; done_prev_bt = 1'b0; done_busy = 1'b1;
        for (int k = 1; k < 100 && done_at < 0; k++) begin
            clk_adv();
            timer_start = (k == 8);
            timer_len = 16'd7;
            @(negedge clk);
            if (timer_done) begin
                done_at = k; done_prev_bt = prev_bt; done_busy = timer_busy;
            end else begin
                if (!timer_busy) busy_gaps++;
                if (base_tick) nbt++;
            end
            prev_bt = base_tick;
        end
        timer_start = 1'b0;
        check("timer4_base_ticks", 32'(nbt), 4);
        check("timer4_done_after_bt", 32'(done_prev_bt), 1);
        check("timer4_busy_falls_with_done", 32'(done_busy), 0);
        check("timer4_busy_continuous", 32'(busy_gaps), 0);
        ndone = 0;
        repeat (40) begin
            clk_adv();
            @(negedge clk);
            if (timer_done || timer_busy) ndone++;
        end
        check("timer4_single_done", 32'(ndone), 0);

        // pause with two base ticks left
        ch_en = 4'b1000;
        clk_adv();
        timer_start = 1'b1; timer_len = 16'd4;
        clk_adv();
        timer_start = 1'b0;
        nbt = 0;
        for (int k = 0; k < 60 && nbt < 2; k++) begin
            @(negedge clk);
            if (base_tick) nbt++;
            if (nbt < 2) clk_adv();
        end
        check("pause_setup_ticks", 32'(nbt), 2);
        clk_adv();
        pause = 1'b1;
        npulse = 0;
        repeat (50) begin
            @(negedge clk);
            if (base_tick || (tick != '0) || timer_done) npulse++;
            if (!timer_busy) npulse++;
            clk_adv();
        end
        pause = 1'b0;
        check("pause_quiet", 32'(npulse), 0);
        nbt = 0; done_at = -1;
        for (int k = 0; k < 80 && done_at < 0; k++) begin
            @(negedge clk);
            if (timer_done) done_at = k;
            else if (base_tick) nbt++;
            clk_adv();
        end
        check("resume_ticks_to_done", 32'(nbt), 2);

        // zero length: done without busy
        ch_en = '0;
        timer_start = 1'b1; timer_len = 16'd0;
        clk_adv();
        timer_start = 1'b0;
        @(negedge clk);
        check("len0_done", 32'(timer_done), 1);
        check("len0_busy", 32'(timer_busy), 0);
        clk_adv();
        @(negedge clk);
        check("len0_done_single", 32'(timer_done), 0);
        check("len0_busy_after", 32'(timer_busy), 0);

        // reset during a run aborts silently
        clk_adv();
        timer_start = 1'b1; timer_len = 16'd3;
        clk_adv();
        timer_start = 1'b0;
        repeat (12) clk_adv();
        @(negedge clk);
        check("abort_setup_busy", 32'(timer_busy), 1);
        clk_adv();
        reset = 1'b1;
        clk_adv();
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(timer_busy), 0);
        ndone = 0;
        repeat (60) begin
            clk_adv();
            @(negedge clk);
            if (timer_done || timer_busy) ndone++;
        end
        check("abort_no_done", 32'(ndone), 0);

        // randomized traffic against the model
        pause_left = 0;
        for (int c = 0; c < 4000; c++) begin
            clk_adv();
            reset = ($urandom_range(0, 399) == 0);
            if (pause_left > 0) pause_left--;
            else if ($urandom_range(0, 59) == 0) pause_left = $urandom_range(1, 25);
            pause = (pause_left > 0);
            cfg_we = 1'b0;
            timer_start = 1'b0;
            if (!pause) begin
                cfg_we = ($urandom_range(0, 24) == 0);
                cfg_ch = 3'($urandom_range(0, 7));
                cfg_div = 16'($urandom_range(0, 5));
                if ($urandom_range(0, 39) == 0) ch_en = 4'($urandom_range(0, 15));
                timer_start = ($urandom_range(0, 14) == 0);
                timer_len = 16'($urandom_range(0, 6));
            end
        end
        clk_adv();
        reset = 1'b0; pause = 1'b0; cfg_we = 1'b0; timer_start = 1'b0;
        clk_adv();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
